// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: frame FSM, LSB-first serializer, parity and baud timing.
// Everything that shapes a frame is captured at acceptance, so the live inputs never disturb a frame in flight.
`timescale 1ns/1ps

module uart_tx_frame_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      CLK,
    input  logic                      Reset,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_valid,
    input  logic                      Parity_EN,
    input  logic                      Parity_type,
    input  logic                      Stop2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy,
    output logic                      Done
);

    localparam int BIT_CNT_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_WIDTH-1:0] LAST_DATA_BIT = BIT_CNT_WIDTH'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic [2:0]                state, state_nxt;
    logic [PRESCALE_WIDTH-1:0] presc_cnt, presc_cnt_nxt;
    logic [PRESCALE_WIDTH-1:0] presc_last;
    logic [BIT_CNT_WIDTH-1:0]  bit_cnt, bit_cnt_nxt;
    logic                      stop_cnt, stop_cnt_nxt;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      parity_en_q;
    logic                      parity_type_q;
    logic                      stop2_q;
    logic                      tx_q, tx_nxt;
    logic                      accept;
    logic                      last_tick;
    logic                      last_stop;
    logic                      parity_bit;

    assign accept     = (state == ST_IDLE) && Data_valid;
    assign last_tick  = (presc_cnt == presc_last);
    assign last_stop  = (stop_cnt == stop2_q);
    assign parity_bit = (^data_q) ^ parity_type_q;

    // Frame sequencing; every counter returns to zero on the bit boundary that ends its use.
    always_comb begin
        // NOTE: every signal gets a default up front so no path through the case can infer a latch.
        state_nxt     = state;
        presc_cnt_nxt = presc_cnt;
        bit_cnt_nxt   = bit_cnt;
        stop_cnt_nxt  = stop_cnt;

        case (state)
            ST_IDLE: begin
                presc_cnt_nxt = '0;
                if (Data_valid) begin
                    state_nxt = ST_START;
                end
            end

            ST_START: begin
                if (last_tick) begin
                    presc_cnt_nxt = '0;
                    bit_cnt_nxt   = '0;
                    state_nxt     = ST_DATA;
                end else begin
                    presc_cnt_nxt = presc_cnt + PRESCALE_WIDTH'(1);
                end
            end

            ST_DATA: begin
                if (last_tick) begin
                    presc_cnt_nxt = '0;
                    if (bit_cnt == LAST_DATA_BIT) begin
                        bit_cnt_nxt  = '0;
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = parity_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_CNT_WIDTH'(1);
                    end
                end else begin
                    presc_cnt_nxt = presc_cnt + PRESCALE_WIDTH'(1);
                end
            end

            ST_PARITY: begin
                if (last_tick) begin
                    presc_cnt_nxt = '0;
                    stop_cnt_nxt  = 1'b0;
                    state_nxt     = ST_STOP;
                end else begin
                    presc_cnt_nxt = presc_cnt + PRESCALE_WIDTH'(1);
                end
            end

            ST_STOP: begin
                if (last_tick) begin
                    presc_cnt_nxt = '0;
                    if (last_stop) begin
                        stop_cnt_nxt = 1'b0;
                        state_nxt    = ST_IDLE;
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end else begin
                    presc_cnt_nxt = presc_cnt + PRESCALE_WIDTH'(1);
                end
            end

            default: begin
                presc_cnt_nxt = '0;
                bit_cnt_nxt   = '0;
                stop_cnt_nxt  = 1'b0;
                state_nxt     = ST_IDLE;
            end
        endcase
    end

    // Line level for the state being entered, so TX_OUT can come straight from a flop.
    always_comb begin
        tx_nxt = 1'b1;
        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = data_q[bit_cnt_nxt];
            ST_PARITY: tx_nxt = parity_bit;
            default:   tx_nxt = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            presc_cnt <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_nxt;
            presc_cnt <= presc_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            stop_cnt  <= stop_cnt_nxt;
            tx_q      <= tx_nxt;
        end
    end

    // Frame configuration is captured only on acceptance; a zero prescale runs at one clock per bit.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            data_q        <= '0;
            parity_en_q   <= 1'b0;
            parity_type_q <= 1'b0;
            stop2_q       <= 1'b0;
            presc_last    <= '0;
        end else if (accept) begin
            data_q        <= P_DATA;
            parity_en_q   <= Parity_EN;
            parity_type_q <= Parity_type;
            stop2_q       <= Stop2;
            presc_last    <= (Prescale == '0) ? '0 : Prescale - PRESCALE_WIDTH'(1);
        end
    end

    assign TX_OUT = tx_q;
    assign Busy   = (state != ST_IDLE);
    assign Done   = (state == ST_STOP) && last_tick && last_stop;

    a_done_only_in_stop: assert property (@(posedge CLK) disable iff (!Reset)
        Done |-> (state == ST_STOP));
    a_idle_line_high: assert property (@(posedge CLK) disable iff (!Reset)
        !Busy |-> TX_OUT);

endmodule
